fpu: RTL and testbench

- Single-precision floating-point coprocessor (MIPS COP1 subset) with a 32x32-bit FPR file.
- Driven by the processor's decoded 4-bit op code and register fields.
- Supports add/sub/mul/div, paired-single (PS) add/sub/mul, format conversions, and GPR<->FPR moves (mtc1/mfc1).
- Sits beside the processor; the data memory serves as the GPR file.

---
 rtl/fpu_pkg.sv | 52 +++++
 rtl/fpu_sp_lane.sv | 200 ++++++++++++++++++++
 rtl/fpu.sv | 177 +++++++++++++++++
 tb/tb_fpu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the COP1 single-precision coprocessor: op codes,
// special encodings, lane operation select and instruction field helpers.
package fpu_pkg;

  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF = 32'hFF80_0000;
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;

  localparam logic [3:0] OP_IDLE     = 4'd0;
  localparam logic [3:0] OP_ADD_S    = 4'd1;
  localparam logic [3:0] OP_ADD_PS   = 4'd2;
  localparam logic [3:0] OP_SUB_S    = 4'd3;
  localparam logic [3:0] OP_SUB_PS   = 4'd4;
  localparam logic [3:0] OP_MUL_S    = 4'd5;
  localparam logic [3:0] OP_MUL_PS   = 4'd6;
  localparam logic [3:0] OP_DIV_S    = 4'd7;
  localparam logic [3:0] OP_CVT_PS_S = 4'd8;
  localparam logic [3:0] OP_CVT_S_W  = 4'd9;
  localparam logic [3:0] OP_CVT_W_S  = 4'd10;
  localparam logic [3:0] OP_CVT_S_PL = 4'd11;
  localparam logic [3:0] OP_CVT_S_PU = 4'd12;
  localparam logic [3:0] OP_MFC1     = 4'd13;
  localparam logic [3:0] OP_MTC1     = 4'd14;

  localparam int FT_LSB = 0;
  localparam int FS_LSB = 5;
  localparam int FD_LSB = 10;

  typedef enum logic [1:0] {
    LANE_ADD = 2'd0,
    LANE_SUB = 2'd1,
    LANE_MUL = 2'd2,
    LANE_DIV = 2'd3
  } lane_op_e;

  function automatic logic [REG_AW-1:0] arg_ft(input logic [14:0] arg);
    return REG_AW'(arg >> FT_LSB);
  endfunction

  function automatic logic [REG_AW-1:0] arg_fs(input logic [14:0] arg);
    return REG_AW'(arg >> FS_LSB);
  endfunction

  function automatic logic [REG_AW-1:0] arg_fd(input logic [14:0] arg);
    return REG_AW'(arg >> FD_LSB);
  endfunction

endpackage

// File: rtl/fpu_sp_lane.sv
// Combinational single-precision add/sub/mul/div lane with round-toward-zero,
// subnormal flush-to-zero and a single exception flag.
module fpu_sp_lane
  import fpu_pkg::*;
(
  input  lane_op_e    op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y,
  output logic        exc
);

  logic        sa, sb, sb_eff, s_xor;
  logic [7:0]  ea, eb;
  logic [23:0] ma, mb;
  logic        za, zb, ia, ib, na, nb;

  assign sa     = a[31];
  assign sb     = b[31];
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign ma     = {1'b1, a[22:0]};
  assign mb     = {1'b1, b[22:0]};
  assign za     = (ea == 8'h00);
  assign zb     = (eb == 8'h00);
  assign ia     = (ea == 8'hFF) && (a[22:0] == 23'h0);
  assign ib     = (eb == 8'hFF) && (b[22:0] == 23'h0);
  assign na     = (ea == 8'hFF) && (a[22:0] != 23'h0);
  assign nb     = (eb == 8'hFF) && (b[22:0] != 23'h0);
  assign sb_eff = sb ^ (op == LANE_SUB);
  assign s_xor  = sa ^ sb;

  // {overflow, word}: overflow saturates to signed Inf, underflow to signed zero
  function automatic logic [32:0] pack_tz(input logic s, input logic signed [10:0] e,
                                          input logic [22:0] m);
    if (e >= 11'sd255) return {1'b1, (s ? NEG_INF : POS_INF)};
    if (e <= 11'sd0)   return {1'b0, s, 31'h0};
    return {1'b0, s, 8'(e), m};
  endfunction

  function automatic logic [5:0] lzc51(input logic [50:0] v);
    logic [5:0] n;
    n = 6'd51;
    for (int i = 0; i < 51; i++) begin
      if (v[i]) n = 6'(50 - i);
    end
    return n;
  endfunction

  function automatic logic [31:0] inf_of(input logic s);
    return s ? NEG_INF : POS_INF;
  endfunction

  // Add/sub: align the smaller magnitude with a sticky bit so truncation is exact
  logic               swap, s_big, s_sml, eff_sub;
  logic [7:0]         e_big, e_sml, d;
  logic [23:0]        m_big, m_sml;
  logic [49:0]        sml_full, sml_shr, sml_al, big_al;
  logic               sml_lost;
  logic [50:0]        add_raw;
  logic [5:0]         add_lz;
  logic signed [10:0] add_e;
  logic [22:0]        add_m;
  logic [32:0]        add_pk;
  logic [31:0]        add_y;
  logic               add_exc;

  assign swap     = {eb, mb} > {ea, ma};
  assign e_big    = swap ? eb : ea;
  assign e_sml    = swap ? ea : eb;
  assign m_big    = swap ? mb : ma;
  assign m_sml    = swap ? ma : mb;
  assign s_big    = swap ? sb_eff : sa;
  assign s_sml    = swap ? sa : sb_eff;
  assign eff_sub  = s_big ^ s_sml;
  assign d        = e_big - e_sml;
  assign sml_full = {m_sml, 26'h0};
  assign sml_shr  = sml_full >> d;
  assign sml_lost = (sml_shr << d) != sml_full;
  assign sml_al   = {sml_shr[49:1], sml_shr[0] | sml_lost};
  assign big_al   = {m_big, 26'h0};
  assign add_raw  = eff_sub ? ({1'b0, big_al} - {1'b0, sml_al})
                            : ({1'b0, big_al} + {1'b0, sml_al});
  assign add_lz   = lzc51(add_raw);
  assign add_e    = $signed({3'b000, e_big}) + 11'sd1 - $signed({5'b00000, add_lz});
  assign add_m    = 23'((add_raw << add_lz) >> 27);
  assign add_pk   = pack_tz(s_big, add_e, add_m);

  always_comb begin
    add_y   = add_pk[31:0];
    add_exc = add_pk[32];
    if (na || nb) begin
      add_y   = QNAN;
      add_exc = 1'b1;
    end else if (ia && ib) begin
      add_y   = (sa == sb_eff) ? inf_of(sa) : QNAN;
      add_exc = (sa != sb_eff);
    end else if (ia) begin
      add_y   = inf_of(sa);
      add_exc = 1'b0;
    end else if (ib) begin
      add_y   = inf_of(sb_eff);
      add_exc = 1'b0;
    end else if (za && zb) begin
      add_y   = 32'h0;
      add_exc = 1'b0;
    end else if (za) begin
      add_y   = {sb_eff, b[30:0]};
      add_exc = 1'b0;
    end else if (zb) begin
      add_y   = a;
      add_exc = 1'b0;
    end else if (add_raw == 51'h0) begin
      add_y   = 32'h0;
      add_exc = 1'b0;
    end
  end

  // Multiply: 24x24 product lies in [2^46, 2^48)
  logic [47:0]        prod;
  logic signed [10:0] mul_e;
  logic [22:0]        mul_m;
  logic [32:0]        mul_pk;
  logic [31:0]        mul_y;
  logic               mul_exc;

  assign prod   = ma * mb;
  assign mul_e  = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
                + $signed({10'h000, prod[47]});
  assign mul_m  = prod[47] ? 23'(prod >> 24) : 23'(prod >> 23);
  assign mul_pk = pack_tz(s_xor, mul_e, mul_m);

  always_comb begin
    mul_y   = mul_pk[31:0];
    mul_exc = mul_pk[32];
    if (na || nb || (ia && zb) || (za && ib)) begin
      mul_y   = QNAN;
      mul_exc = 1'b1;
    end else if (ia || ib) begin
      mul_y   = inf_of(s_xor);
      mul_exc = 1'b0;
    end else if (za || zb) begin
      mul_y   = {s_xor, 31'h0};
      mul_exc = 1'b0;
    end
  end

  // Divide: ma*2^25/mb lies in (2^24, 2^26); integer division truncates
  logic [48:0]        quo;
  logic signed [10:0] div_e;
  logic [22:0]        div_m;
  logic [32:0]        div_pk;
  logic [31:0]        div_y;
  logic               div_exc;

  assign quo    = {ma, 25'h0} / {25'h0, mb};
  assign div_e  = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd126
                + $signed({10'h000, quo[25]});
  assign div_m  = quo[25] ? 23'(quo >> 2) : 23'(quo >> 1);
  assign div_pk = pack_tz(s_xor, div_e, div_m);

  always_comb begin
    div_y   = div_pk[31:0];
    div_exc = div_pk[32];
    if (na || nb || (ia && ib) || (za && zb)) begin
      div_y   = QNAN;
      div_exc = 1'b1;
    end else if (ia) begin
      div_y   = inf_of(s_xor);
      div_exc = 1'b0;
    end else if (ib) begin
      div_y   = {s_xor, 31'h0};
      div_exc = 1'b0;
    end else if (zb) begin
      div_y   = inf_of(s_xor);
      div_exc = 1'b1;
    end else if (za) begin
      div_y   = {s_xor, 31'h0};
      div_exc = 1'b0;
    end
  end

  always_comb begin
    case (op)
      LANE_MUL: begin
        y   = mul_y;
        exc = mul_exc;
      end
      LANE_DIV: begin
        y   = div_y;
        exc = div_exc;
      end
      default: begin
        y   = add_y;
        exc = add_exc;
      end
    endcase
  end

endmodule

// File: rtl/fpu.sv
// COP1 subset top: 32-entry FPR file, op decode, conversions and GPR moves;
// arithmetic comes from two lanes (lower and upper paired-single element).
module fpu
  import fpu_pkg::*;
(
  input  logic        fpu_clock,
  input  logic        fpu_reset_b,
  input  logic [3:0]  fpu_instr,
  input  logic [14:0] argument,
  input  logic [31:0] data_GPR,
  output logic [31:0] result,
  output logic        exception,
  output logic [31:0] data_FPR
);

  logic [31:0] fpr [NREG];

  logic [REG_AW-1:0] ft, fs, fd, ft_hi, fs_hi, fd_hi;
  logic [31:0]       fs_val, ft_val, fs_hi_val, ft_hi_val;

  assign ft        = arg_ft(argument);
  assign fs        = arg_fs(argument);
  assign fd        = arg_fd(argument);
  assign ft_hi     = ft + 1'b1;
  assign fs_hi     = fs + 1'b1;
  assign fd_hi     = fd + 1'b1;
  assign fs_val    = fpr[fs];
  assign ft_val    = fpr[ft];
  assign fs_hi_val = fpr[fs_hi];
  assign ft_hi_val = fpr[ft_hi];
  assign data_FPR  = fs_val;

  function automatic logic [31:0] i2f_tz(input logic signed [31:0] v);
    logic [31:0] mag;
    logic [4:0]  msb;
    if (v == 32'sd0) return 32'h0;
    mag = v[31] ? $unsigned(-v) : $unsigned(v);
    msb = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    return {v[31], 8'd127 + {3'b000, msb}, 23'((mag << (5'd31 - msb)) >> 8)};
  endfunction

  // {invalid, word}: truncates toward zero, saturates out-of-range/NaN/Inf to INT_MAX
  function automatic logic [32:0] f2i_sat(input logic [31:0] f);
    logic [7:0]        e;
    logic signed [9:0] u;
    logic [31:0]       mag;
    e = f[30:23];
    u = $signed({2'b00, e}) - 10'sd127;
    if (e == 8'hFF) return {1'b1, INT_MAX};
    if (u < 10'sd0) return 33'h0;
    if (u >= 10'sd31) begin
      if (f[31] && (u == 10'sd31) && (f[22:0] == 23'h0)) return {1'b0, 32'h8000_0000};
      return {1'b1, INT_MAX};
    end
    if (u >= 10'sd23) mag = {8'h00, 1'b1, f[22:0]} << (u - 10'sd23);
    else              mag = {8'h00, 1'b1, f[22:0]} >> (10'sd23 - u);
    return {1'b0, (f[31] ? (~mag + 32'd1) : mag)};
  endfunction

  lane_op_e    lane_op_p0;
  logic [31:0] lo_y, hi_y;
  logic        lo_exc, hi_exc;

  always_comb begin
    case (fpu_instr)
      OP_SUB_S, OP_SUB_PS: lane_op_p0 = LANE_SUB;
      OP_MUL_S, OP_MUL_PS: lane_op_p0 = LANE_MUL;
      OP_DIV_S:            lane_op_p0 = LANE_DIV;
      default:             lane_op_p0 = LANE_ADD;
    endcase
  end

  fpu_sp_lane u_lane_lo (
    .op  (lane_op_p0),
    .a   (fs_val),
    .b   (ft_val),
    .y   (lo_y),
    .exc (lo_exc)
  );

  fpu_sp_lane u_lane_hi (
    .op  (lane_op_p0),
    .a   (fs_hi_val),
    .b   (ft_hi_val),
    .y   (hi_y),
    .exc (hi_exc)
  );

  logic              vld_lo_p0, vld_hi_p0, res_we_p0, exc_we_p0, exc_p0;
  logic [REG_AW-1:0] lo_addr_p0;
  logic [31:0]       lo_data_p0, hi_data_p0;
  logic [32:0]       cvt_w_p0;

  assign cvt_w_p0 = f2i_sat(fs_val);

  always_comb begin
    vld_lo_p0  = 1'b0;
    vld_hi_p0  = 1'b0;
    res_we_p0  = 1'b1;
    exc_we_p0  = 1'b1;
    exc_p0     = 1'b0;
    lo_addr_p0 = fd;
    lo_data_p0 = lo_y;
    hi_data_p0 = hi_y;
    case (fpu_instr)
      OP_ADD_S, OP_SUB_S, OP_MUL_S, OP_DIV_S: begin
        vld_lo_p0 = 1'b1;
        exc_p0    = lo_exc;
      end
      OP_ADD_PS, OP_SUB_PS, OP_MUL_PS: begin
        vld_lo_p0 = 1'b1;
        vld_hi_p0 = 1'b1;
        exc_p0    = lo_exc | hi_exc;
      end
      OP_CVT_PS_S: begin
        vld_lo_p0  = 1'b1;
        vld_hi_p0  = 1'b1;
        lo_data_p0 = ft_val;
        hi_data_p0 = fs_val;
      end
      OP_CVT_S_W: begin
        vld_lo_p0  = 1'b1;
        lo_data_p0 = i2f_tz(fs_val);
      end
      OP_CVT_W_S: begin
        vld_lo_p0  = 1'b1;
        lo_data_p0 = cvt_w_p0[31:0];
        exc_p0     = cvt_w_p0[32];
      end
      OP_CVT_S_PL: begin
        vld_lo_p0  = 1'b1;
        lo_data_p0 = fs_val;
      end
      OP_CVT_S_PU: begin
        vld_lo_p0  = 1'b1;
        lo_data_p0 = fs_hi_val;
      end
      OP_MFC1: begin
        res_we_p0 = 1'b0;
        exc_we_p0 = 1'b0;
      end
      OP_MTC1: begin
        vld_lo_p0  = 1'b1;
        lo_addr_p0 = fs;
        lo_data_p0 = data_GPR;
        res_we_p0  = 1'b0;
        exc_we_p0  = 1'b0;
      end
      OP_IDLE: res_we_p0 = 1'b0;
      default: res_we_p0 = 1'b0;
    endcase
  end

  // p0 -> p1: register file write, result and exception capture
  logic [31:0] result_p1;
  logic        exc_p1;

  always_ff @(posedge fpu_clock) begin
    if (fpu_reset_b) begin
      for (int i = 0; i < NREG; i++) fpr[i] <= 32'h0;
      result_p1 <= 32'h0;
      exc_p1    <= 1'b0;
    end else begin
      if (vld_lo_p0) fpr[lo_addr_p0] <= lo_data_p0;
      if (vld_hi_p0) fpr[fd_hi] <= hi_data_p0;
      if (res_we_p0) result_p1 <= lo_data_p0;
      if (exc_we_p0) exc_p1 <= exc_p0;
    end
  end

  assign result    = result_p1;
  assign exception = exc_p1;

endmodule

// File: tb/tb_fpu.sv
// Directed-vector bench for fpu: moves, scalar and paired-single arithmetic,
// exceptions, conversions, register wrap and reset priority.
module tb_fpu;

  localparam logic [3:0] I_IDLE     = 4'd0;
  localparam logic [3:0] I_ADD_S    = 4'd1;
  localparam logic [3:0] I_ADD_PS   = 4'd2;
  localparam logic [3:0] I_SUB_S    = 4'd3;
  localparam logic [3:0] I_SUB_PS   = 4'd4;
  localparam logic [3:0] I_MUL_S    = 4'd5;
  localparam logic [3:0] I_MUL_PS   = 4'd6;
  localparam logic [3:0] I_DIV_S    = 4'd7;
  localparam logic [3:0] I_CVT_PS_S = 4'd8;
  localparam logic [3:0] I_CVT_S_W  = 4'd9;
  localparam logic [3:0] I_CVT_W_S  = 4'd10;
  localparam logic [3:0] I_CVT_S_PL = 4'd11;
  localparam logic [3:0] I_CVT_S_PU = 4'd12;
  localparam logic [3:0] I_MFC1     = 4'd13;
  localparam logic [3:0] I_MTC1     = 4'd14;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  instr = 4'd0;
  logic [14:0] arg = 15'h0;
  logic [31:0] gpr = 32'h0;
  logic [31:0] result, data_fpr;
  logic        exception;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fpu dut (
    .fpu_clock   (clk),
    .fpu_reset_b (rst),
    .fpu_instr   (instr),
    .argument    (arg),
    .data_GPR    (gpr),
    .result      (result),
    .exception   (exception),
    .data_FPR    (data_fpr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic exec(input logic [3:0] code, input int fd, input int fs, input int ft,
                      input logic [31:0] g = 32'h0);
    @(negedge clk);
    instr = code;
    arg   = {5'(fd), 5'(fs), 5'(ft)};
    gpr   = g;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    @(negedge clk);
    instr = I_MFC1;
    arg   = {5'd0, 5'(idx), 5'd0};
    #1;
    v = data_fpr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "tb_fpu watchdog expired");
  end

  initial begin
    logic [31:0] v;

    // reset held two edges with an op present
    rst   = 1'b1;
    instr = I_ADD_S;
    arg   = {5'd3, 5'd1, 5'd2};
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 32'h0);
    check("rst_exc", {31'h0, exception}, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    instr = I_IDLE;
    rd(0, v);  check("rst_r0", v, 32'h0);
    rd(17, v); check("rst_r17", v, 32'h0);
    rd(31, v); check("rst_r31", v, 32'h0);

    // moves
    exec(I_MTC1, 0, 1, 0, 32'h3F80_0000);
    exec(I_MTC1, 0, 2, 0, 32'h4000_0000);
    rd(2, v); check("mfc1_r2", v, 32'h4000_0000);
    rd(1, v); check("mfc1_r1", v, 32'h3F80_0000);
    check("mtc1_keeps_result", result, 32'h0);

    // scalar arithmetic
    exec(I_ADD_S, 3, 1, 2);
    check("add_s", result, 32'h4040_0000);
    check("add_s_exc", {31'h0, exception}, 32'h0);
    exec(I_MUL_S, 4, 3, 2);
    check("mul_s", result, 32'h40C0_0000);
    exec(I_SUB_S, 5, 1, 2);
    check("sub_s", result, 32'hBF80_0000);
    exec(I_DIV_S, 6, 1, 2);
    check("div_s", result, 32'h3F00_0000);
    rd(4, v); check("mul_s_reg", v, 32'h40C0_0000);

    // exceptions
    exec(I_MTC1, 0, 7, 0, 32'h0);
    exec(I_DIV_S, 13, 1, 7);
    check("div_zero", result, 32'h7F80_0000);
    check("div_zero_exc", {31'h0, exception}, 32'h1);
    exec(I_IDLE, 0, 0, 0);
    check("idle_exc_clear", {31'h0, exception}, 32'h0);
    check("idle_result_held", result, 32'h7F80_0000);
    exec(I_MTC1, 0, 14, 0, 32'h7F00_0000);
    exec(I_MUL_S, 15, 14, 2);
    check("mul_ovf", result, 32'h7F80_0000);
    check("mul_ovf_exc", {31'h0, exception}, 32'h1);
    exec(I_MTC1, 0, 16, 0, 32'h7FC0_0000);
    exec(I_ADD_S, 17, 16, 1);
    check("add_nan", result, 32'h7FC0_0000);
    check("add_nan_exc", {31'h0, exception}, 32'h1);
    exec(I_SUB_S, 30, 15, 15);
    check("inf_minus_inf", result, 32'h7FC0_0000);
    check("inf_minus_inf_exc", {31'h0, exception}, 32'h1);

    // conversions
    exec(I_MTC1, 0, 18, 0, 32'hFFFF_FFF9);
    exec(I_CVT_S_W, 19, 18, 0);
    check("cvt_s_w", result, 32'hC0E0_0000);
    check("cvt_s_w_exc", {31'h0, exception}, 32'h0);
    exec(I_MTC1, 0, 20, 0, 32'h4049_0FDB);
    exec(I_CVT_W_S, 21, 20, 0);
    check("cvt_w_s_pi", result, 32'h0000_0003);
    exec(I_MTC1, 0, 22, 0, 32'h4F80_0000);
    exec(I_CVT_W_S, 23, 22, 0);
    check("cvt_w_s_sat", result, 32'h7FFF_FFFF);
    check("cvt_w_s_sat_exc", {31'h0, exception}, 32'h1);
    exec(I_MTC1, 0, 22, 0, 32'hCF00_0000);
    exec(I_CVT_W_S, 23, 22, 0);
    check("cvt_w_s_intmin", result, 32'h8000_0000);
    check("cvt_w_s_intmin_exc", {31'h0, exception}, 32'h0);

    // paired single
    exec(I_CVT_PS_S, 8, 2, 1);
    check("cvt_ps_s_result", result, 32'h3F80_0000);
    rd(8, v); check("cvt_ps_s_lo", v, 32'h3F80_0000);
    rd(9, v); check("cvt_ps_s_hi", v, 32'h4000_0000);
    exec(I_ADD_PS, 10, 8, 8);
    check("add_ps_result", result, 32'h4000_0000);
    rd(10, v); check("add_ps_lo", v, 32'h4000_0000);
    rd(11, v); check("add_ps_hi", v, 32'h4080_0000);
    exec(I_MUL_PS, 24, 10, 8);
    rd(24, v); check("mul_ps_lo", v, 32'h4000_0000);
    rd(25, v); check("mul_ps_hi", v, 32'h4100_0000);
    exec(I_SUB_PS, 28, 10, 8);
    rd(28, v); check("sub_ps_lo", v, 32'h3F80_0000);
    rd(29, v); check("sub_ps_hi", v, 32'h4000_0000);
    exec(I_CVT_S_PU, 12, 10, 0);
    check("cvt_s_pu", result, 32'h4080_0000);
    exec(I_CVT_S_PL, 13, 10, 0);
    check("cvt_s_pl", result, 32'h4000_0000);

    // register 31 pairs with register 0
    exec(I_CVT_PS_S, 31, 2, 1);
    rd(0, v); check("wrap_cvt_r0", v, 32'h4000_0000);
    exec(I_ADD_PS, 31, 31, 31);
    check("wrap_add_result", result, 32'h4000_0000);
    rd(0, v); check("wrap_add_r0", v, 32'h4080_0000);

    // truncation with far-aligned operand, and fd overlapping sources
    exec(I_MTC1, 0, 26, 0, 32'h3080_0000);
    exec(I_SUB_S, 27, 1, 26);
    check("sub_trunc", result, 32'h3F7F_FFFF);
    exec(I_ADD_S, 1, 1, 1);
    rd(1, v); check("overlap_r1", v, 32'h4000_0000);

    // reset wins over an op in the same cycle
    @(negedge clk);
    rst   = 1'b1;
    instr = I_ADD_S;
    arg   = {5'd3, 5'd1, 5'd2};
    @(posedge clk);
    #1;
    check("midrst_result", result, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    instr = I_IDLE;
    rd(3, v);  check("midrst_r3", v, 32'h0);
    rd(1, v);  check("midrst_r1", v, 32'h0);
    rd(11, v); check("midrst_r11", v, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
